// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard detection and stall control with a multi-cycle data-memory wait FSM.
// Optional stall performance counter enabled by defining STALL_COUNTER_EN.
module hazard_stall_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MEM_LAT    = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  IDEX_MemRead,
  input  logic                  IDEX_RegWrite,
  input  logic [REG_ADDR_W-1:0] IDEX_DestReg,
  input  logic                  EXMEM_MemRead,
  input  logic                  EXMEM_MemWrite,
  input  logic [REG_ADDR_W-1:0] EXMEM_RegRd,
  input  logic [REG_ADDR_W-1:0] IFID_RegRs,
  input  logic [REG_ADDR_W-1:0] IFID_RegRt,
  input  logic                  MemWrite,
  input  logic                  Branch,
  output logic                  PCWrite,
  output logic                  IFID_Write,
  output logic                  HazZero,
  output logic                  EXMEM_Hold,
  output logic [1:0]            HazCause,
  output logic [CNT_W-1:0]      StallCount
);

  localparam int CW = $clog2(MEM_LAT + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;

  logic hz_a, hz_b, hz_c, mem_use;
  logic mem_stall, hold_raw, stall;
  logic [1:0] cause;

  always_comb begin
    hz_a = IDEX_MemRead && (IDEX_DestReg != '0) &&
           ((IFID_RegRs == IDEX_DestReg) || ((IFID_RegRt == IDEX_DestReg) && !MemWrite));
    hz_b = Branch && IDEX_RegWrite && (IDEX_DestReg != '0) &&
           ((IFID_RegRs == IDEX_DestReg) || (IFID_RegRt == IDEX_DestReg));
    hz_c = Branch && EXMEM_MemRead && (EXMEM_RegRd != '0) &&
           ((IFID_RegRs == EXMEM_RegRd) || (IFID_RegRt == EXMEM_RegRd));
    mem_use = EXMEM_MemRead || EXMEM_MemWrite;
  end

  // In WAIT the EX/MEM register is frozen, so MemUse no longer matters.
  always_comb begin
    mem_stall = 1'b0;
    hold_raw  = 1'b0;
    if (state == WAIT) begin
      mem_stall = 1'b1;
      hold_raw  = (cnt > CW'(1));
    end else if (mem_use) begin
      mem_stall = 1'b1;
      hold_raw  = (MEM_LAT > 1);
    end
  end

  always_comb begin
    stall = mem_stall || hz_a || hz_b || hz_c;
    if (mem_stall)          cause = 2'd1;
    else if (hz_a)          cause = 2'd2;
    else if (hz_b || hz_c)  cause = 2'd3;
    else                    cause = 2'd0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_use && (MEM_LAT > 1)) begin
            state <= WAIT;
            cnt   <= CW'(MEM_LAT - 1);
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Outputs are gated by reset_n so reset values appear without waiting for a clock edge.
  always_comb begin
    PCWrite    = reset_n && !stall;
    IFID_Write = reset_n && !stall;
    HazZero    = !reset_n || stall;
    EXMEM_Hold = reset_n && hold_raw;
    HazCause   = reset_n ? cause : 2'd0;
  end

`ifdef STALL_COUNTER_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      stall_cnt <= '0;
    else if (!PCWrite && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign StallCount = stall_cnt;
`else
  assign StallCount = '0;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Parametrised hazard detection and stall controller for the 5-stage MIPS32 pipeline. It is the next generation of the ID-stage hazard unit.
- Same load-use and branch-in-ID hazard checks, now qualified by RegWrite.
- Adds a multi-cycle data-memory wait FSM that freezes EX/MEM for MEM_LAT cycles.
- Adds a stall-cause code and an optional stall performance counter.
- Sits beside the ID stage; drives PC, IF/ID and ID/EX-bubble controls plus the EX/MEM hold.

Parameters:
REG_ADDR_W, 5, register-address width
MEM_LAT, 1, data-memory access latency in cycles, >=1 (1 = single-cycle memory)
CNT_W, 32, stall-counter width

Ports:
clock  in  1  pipeline clock
reset_n  in  1  asynchronous active-low reset
IDEX_MemRead  in  1  EX-stage instruction is a load
IDEX_RegWrite  in  1  EX-stage instruction writes a register
IDEX_DestReg  in  REG_ADDR_W  EX-stage destination register
EXMEM_MemRead  in  1  MEM-stage load
EXMEM_MemWrite  in  1  MEM-stage store
EXMEM_RegRd  in  REG_ADDR_W  MEM-stage destination register
IFID_RegRs  in  REG_ADDR_W  ID-stage rs
IFID_RegRt  in  REG_ADDR_W  ID-stage rt
MemWrite  in  1  ID-stage instruction is a store (rt not needed before MEM)
Branch  in  1  ID-stage instruction is a branch resolved in ID
PCWrite  out  1  PC update enable
IFID_Write  out  1  IF/ID register enable
HazZero  out  1  zero ID/EX control signals (insert bubble)
EXMEM_Hold  out  1  freeze EX/MEM register and MEM stage
HazCause  out  2  0 none, 1 memory wait, 2 load-use, 3 branch
StallCount  out  CNT_W  cycles with PCWrite=0 since reset

Behaviour:
Interface
- Single clock domain, clock rising edge.
- reset_n is asynchronous and active-low.

Reset
- While reset_n=0:
  - PCWrite=0, IFID_Write=0, HazZero=1.
  - EXMEM_Hold=0, HazCause=0, StallCount=0.
  - FSM forced to IDLE, wait counter cleared.
- Reset asserted mid-WAIT abandons the wait immediately; after release the FSM is in IDLE.

Hazard terms (combinational, all from current inputs)
- HzA (load-use): IDEX_MemRead & IDEX_DestReg!=0 & (Rs==IDEX_DestReg | (Rt==IDEX_DestReg & !MemWrite)).
- HzB (branch vs EX): Branch & IDEX_RegWrite & IDEX_DestReg!=0 & (Rs==IDEX_DestReg | Rt==IDEX_DestReg).
- HzC (branch vs load in MEM): Branch & EXMEM_MemRead & EXMEM_RegRd!=0 & (Rs==EXMEM_RegRd | Rt==EXMEM_RegRd).
- MemUse = EXMEM_MemRead | EXMEM_MemWrite.

Memory FSM (states IDLE, WAIT; down-counter of width clog2(MEM_LAT+1))
- IDLE, MemUse=1:
  - memory stall this cycle.
  - If MEM_LAT>1: go to WAIT, cnt=MEM_LAT-1, EXMEM_Hold=1.
  - Else stay IDLE, EXMEM_Hold=0.
- IDLE, MemUse=0: no memory stall.
- WAIT:
  - Memory stall every cycle; MemUse is ignored (EX/MEM is frozen).
  - EXMEM_Hold = (cnt>1).
  - cnt decrements each cycle; when cnt==1, go to IDLE.
- Result: each memory op causes exactly MEM_LAT stall cycles, with EXMEM_Hold high for the first MEM_LAT-1 of them.

Outputs (outside reset)
- stall = memstall | HzA | HzB | HzC.
- PCWrite = IFID_Write = !stall; HazZero = stall.
- HazCause priority: memory (1) > HzA (2) > HzB|HzC (3) > none (0).

Optional Feature:
STALL_COUNTER_EN
- Defined: StallCount increments on each rising edge where PCWrite=0 and reset_n=1; saturates at all-ones and does not wrap.
- Undefined: StallCount tied to 0; no counter flops.

Test Plan:
- MEM_LAT=1, IDLE, EXMEM_MemRead=1 for one cycle -> PCWrite=0, HazZero=1, HazCause=1, EXMEM_Hold=0 for that cycle; next cycle (MemUse=0) PCWrite=1.
- MEM_LAT=3, EXMEM_MemWrite=1 -> stall 3 consecutive cycles; EXMEM_Hold=1,1,0; HazCause=1 throughout; FSM back in IDLE after the third cycle.
- IDEX_MemRead=1, IDEX_DestReg=2, IFID_RegRs=2 -> HazZero=1, HazCause=2; repeat with DestReg=0 -> no stall; repeat with Rt=2, MemWrite=1, Rs!=2 -> no stall.
- Branch=1, IDEX_RegWrite=1, DestReg=3, Rt=3 -> stall, HazCause=3; same with IDEX_RegWrite=0 -> no stall; Branch=1, EXMEM_MemRead=1, EXMEM_RegRd=1, Rs=1 -> memory stall wins, HazCause=1.
- MEM_LAT=4, reset_n pulled low on the second WAIT cycle -> outputs take reset values asynchronously; after release with MemUse=0, PCWrite=1 and HazCause=0.
- STALL_COUNTER_EN, CNT_W=3, hold a stall 10 cycles -> StallCount reaches 7 and stays at 7.
